instr_fetch_unit: RTL

Fetch and PC-sequencing stage for the 16-bit RISC core. It sits directly upstream of the instruction decoder/controller.
- Holds the program counter and fetches from instruction memory with a ready handshake.
- Presents a registered instruction word to the decoder.
- Consumes the decoder's PC_src/Jmp/Jalr/Jr/Hlt outputs to pick the next PC, and halts the core on HLT.

---
 rtl/core_pkg.sv | 30 +++
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit_next_pc_sel.sv | 45 ++++
 rtl/instr_fetch_unit.sv | 96 +++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and types for the 16-bit core front end
package core_pkg;

  localparam int PC_W_DEF = 16;
  localparam int INSTR_W  = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam logic [3:0] OP_ALU = 4'h0;
  localparam logic [3:0] OP_LHI = 4'h3;
  localparam logic [3:0] OP_LW  = 4'h4;
  localparam logic [3:0] OP_SW  = 4'h5;
  localparam logic [3:0] OP_BRN = 4'hC;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int BR_OFF_MSB  = 7;
  localparam int BR_OFF_W    = BR_OFF_MSB + 1;
  localparam int JMP_OFF_MSB = 10;
  localparam int JMP_OFF_W   = JMP_OFF_MSB + 1;

  localparam logic [INSTR_W-1:0] INSTR_RESET = '0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/ready bus
interface instr_fetch_unit_if #(
  parameter int PC_W = 16
);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// rtl/instr_fetch_unit_next_pc_sel.sv - next-PC priority mux with branch/jump offset adders
module next_pc_sel
  import core_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0]      pc,
  input  logic [PC_W-1:0]      reg_target,
  input  logic [BR_OFF_W-1:0]  br_off,
  input  logic [JMP_OFF_W-1:0] jmp_off,
  input  logic                 hlt,
  input  logic                 jr,
  input  logic                 jalr,
  input  logic                 jmp,
  input  logic                 pc_src,
  output logic [PC_W-1:0]      pc_plus1,
  output logic [PC_W-1:0]      next_pc
);

  logic [PC_W-1:0] br_sext;
  logic [PC_W-1:0] jmp_sext;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;

  assign pc_plus1   = pc + PC_W'(1);
  assign br_sext    = {{(PC_W-BR_OFF_W){br_off[BR_OFF_W-1]}}, br_off};
  assign jmp_sext   = {{(PC_W-JMP_OFF_W){jmp_off[JMP_OFF_W-1]}}, jmp_off};
  assign br_target  = pc_plus1 + br_sext;
  assign jmp_target = pc_plus1 + jmp_sext;

  // Halt outranks everything so the halted pc is always the sequential successor.
  always_comb begin
    next_pc = pc_plus1;
    if (hlt) begin
      next_pc = pc_plus1;
    end else if (jr || jalr) begin
      next_pc = reg_target;
    end else if (jmp) begin
      next_pc = jmp_target;
    end else if (pc_src) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch/execute/halt sequencer holding the pc and the instruction register
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  output logic [INSTR_W-1:0]  instr,
  output logic                instr_valid,
  output logic [PC_W-1:0]     pc,
  output logic [PC_W-1:0]     pc_plus1,
  input  logic                exec_stall,
  input  logic                PC_src,
  input  logic                Jmp,
  input  logic                Jalr,
  input  logic                Jr,
  input  logic                Hlt,
  input  logic [PC_W-1:0]     reg_target,
  output logic                halted
);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] next_pc;
  logic [INSTR_W-1:0] instr_q;
  logic            advance;
  logic            capture;

  next_pc_sel #(
    .PC_W (PC_W)
  ) u_next_pc_sel (
    .pc         (pc_q),
    .reg_target (reg_target),
    .br_off     (instr_q[BR_OFF_MSB:0]),
    .jmp_off    (instr_q[JMP_OFF_MSB:0]),
    .hlt        (Hlt),
    .jr         (Jr),
    .jalr       (Jalr),
    .jmp        (Jmp),
    .pc_src     (PC_src),
    .pc_plus1   (pc_plus1),
    .next_pc    (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: if (imem.imem_ready) state_nxt = ST_EXEC;
      ST_EXEC:  if (!exec_stall) state_nxt = Hlt ? ST_HALT : ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  // The reset state is FETCH, so the request is also gated by rst to drop at once.
  always_comb begin
    imem.imem_req  = (state == ST_FETCH) && !rst;
    imem.imem_addr = pc_q;
    instr_valid    = (state == ST_EXEC);
    halted         = (state == ST_HALT);
    advance        = (state == ST_EXEC) && !exec_stall;
    capture        = (state == ST_FETCH) && imem.imem_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (advance) begin
      pc_q <= next_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= INSTR_RESET;
    end else if (capture) begin
      instr_q <= imem.imem_rdata;
    end
  end

  assign pc    = pc_q;
  assign instr = instr_q;

endmodule
